// File: rtl/wb_irq_pkg.sv
// Shared register map and vector-word helpers for the Wishbone interrupt controller.
package wb_irq_pkg;

  localparam logic [7:0] IRQ_PENDING = 8'h00;
  localparam logic [7:0] IRQ_ENABLE  = 8'h04;
  localparam logic [7:0] IRQ_STATUS  = 8'h08;
  localparam logic [7:0] IRQ_RAW     = 8'h0C;
  localparam logic [7:0] IRQ_VECTOR  = 8'h10;

  localparam int VECTOR_VALID_BIT = 31;
  localparam int IDX_W            = 5;

  function automatic logic [31:0] make_vector(input logic valid, input logic [IDX_W-1:0] idx);
    logic [31:0] v;
    v                   = '0;
    v[VECTOR_VALID_BIT] = valid;
    v[IDX_W-1:0]        = idx;
    return v;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; idx_o is 0 when no request is active.
module irq_prio_enc
  import wb_irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: rising-edge capture into W1C pending bits,
// software enable mask, registered CPU interrupt and a priority vector register.
module wb_irq_ctrl
  import wb_irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  input  logic             wb_we_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq_o
);

  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr_mask;
  logic [N_SRC-1:0] status;
  logic [31:0]      dat_q, dat_d;
  logic             ack_q;
  logic             irq_q;
  logic             access, wr, rd;
  logic [7:0]       adr;
  logic             vec_valid;
  logic [IDX_W-1:0] vec_idx;
  logic             unused_bits;

  assign adr    = wb_adr_i[7:0];
  assign access = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr     = access & wb_we_i;
  assign rd     = access & ~wb_we_i;
  assign rise   = irq_src & ~src_q;
  assign status = pending_q & enable_q;

  // Byte selects and upper address bits are deliberately not decoded.
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_dat_i};

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req_i   (status),
    .valid_o (vec_valid),
    .idx_o   (vec_idx)
  );

  always_comb begin
    clr_mask = '0;
    enable_d = enable_q;
    dat_d    = dat_q;
    if (wr && adr == IRQ_PENDING) clr_mask = wb_dat_i[N_SRC-1:0];
    if (wr && adr == IRQ_ENABLE)  enable_d = wb_dat_i[N_SRC-1:0];
    // A new edge is OR-ed in after the clear so a coincident W1C cannot drop it.
    pending_d = (pending_q & ~clr_mask) | rise;
    if (rd) begin
      case (adr)
        IRQ_PENDING: dat_d = 32'(pending_q);
        IRQ_ENABLE:  dat_d = 32'(enable_q);
        IRQ_STATUS:  dat_d = 32'(status);
        IRQ_RAW:     dat_d = 32'(irq_src);
        IRQ_VECTOR:  dat_d = make_vector(vec_valid, vec_idx);
        default:     dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      enable_q  <= '0;
      src_q     <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      src_q     <= irq_src;
      dat_q     <= dat_d;
      ack_q     <= access;
      irq_q     <= |status;
    end
  end

  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed bench for wb_irq_ctrl: read expectations go through a scoreboard queue
// popped by an acknowledge monitor; irq and handshake timing are checked inline.
module tb_wb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic [7:0]  irq_src;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tx     = 0;
  int n_acks   = 0;
  logic [31:0] exp_q[$];

  localparam logic [7:0] A_PEND = 8'h00;
  localparam logic [7:0] A_EN   = 8'h04;
  localparam logic [7:0] A_STAT = 8'h08;
  localparam logic [7:0] A_RAW  = 8'h0C;
  localparam logic [7:0] A_VEC  = 8'h10;

  wb_irq_ctrl #(.N_SRC(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .irq_src  (irq_src),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every read acknowledge pops one expected word.
  always @(negedge clk) begin
    if (!reset && wb_ack_o) begin
      n_acks++;
      if (!wb_we_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got 0x%08h at adr 0x%02h, expected no read", wb_dat_o, wb_adr_i[7:0]);
        end else begin
          check($sformatf("rd_%02h", wb_adr_i[7:0]), wb_dat_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] dat, input logic [7:0] pulse);
    int n;
    @(posedge clk); #1;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {24'h0, adr};
    wb_dat_i = dat;
    irq_src  = irq_src | pulse;
    n_tx++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 10);
    irq_src = irq_src & ~pulse;
    check("ack_latency", 32'(n), 32'd2);
    $display("tx %0d: %s adr=0x%02h wdat=0x%08h rdat=0x%08h pulse=0x%02h", n_tx,
             we ? "WR" : "RD", adr, dat, wb_dat_o, pulse);
    @(posedge clk); #1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
    bus(1'b1, adr, dat, 8'h00);
  endtask

  task automatic rd(input logic [7:0] adr, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus(1'b0, adr, 32'h0, 8'h00);
  endtask

  task automatic pulse_src(input logic [7:0] mask);
    @(posedge clk); #1;
    irq_src = irq_src | mask;
    @(posedge clk); #1;
    irq_src = irq_src & ~mask;
  endtask

  task automatic chk_irq(input string name, input logic exp);
    @(negedge clk);
    check(name, 32'(irq_o), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = 4'hF;
    irq_src  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state of every register
    rd(A_PEND, 32'h0);
    rd(A_EN,   32'h0);
    rd(A_STAT, 32'h0);
    rd(A_RAW,  32'h0);
    rd(A_VEC,  32'h0);
    chk_irq("irq_after_reset", 1'b0);

    // Enabled source 0: capture, vector, clear
    wr(A_EN, 32'h01);
    pulse_src(8'h01);
    chk_irq("irq_src0_k", 1'b0);
    chk_irq("irq_src0_k1", 1'b1);
    rd(A_PEND, 32'h01);
    rd(A_STAT, 32'h01);
    rd(A_VEC,  32'h8000_0000);
    wr(A_PEND, 32'h01);
    chk_irq("irq_src0_cleared", 1'b0);
    rd(A_PEND, 32'h0);

    // Disabled source 3 latches; enabling later raises irq
    wr(A_EN, 32'h00);
    pulse_src(8'h08);
    chk_irq("irq_src3_masked_a", 1'b0);
    chk_irq("irq_src3_masked_b", 1'b0);
    rd(A_PEND, 32'h08);
    rd(A_STAT, 32'h00);
    wr(A_EN, 32'h08);
    chk_irq("irq_src3_enabled", 1'b1);
    wr(A_PEND, 32'h08);
    chk_irq("irq_src3_cleared", 1'b0);

    // Level-held source 2 triggers only once
    @(posedge clk); #1;
    irq_src[2] = 1'b1;
    repeat (3) @(posedge clk);
    rd(A_PEND, 32'h04);
    rd(A_RAW,  32'h04);
    wr(A_PEND, 32'h04);
    rd(A_PEND, 32'h00);
    repeat (5) @(posedge clk);
    rd(A_PEND, 32'h00);
    @(posedge clk); #1;
    irq_src[2] = 1'b0;
    @(posedge clk); #1;
    irq_src[2] = 1'b1;
    repeat (2) @(posedge clk);
    rd(A_PEND, 32'h04);
    @(posedge clk); #1;
    irq_src[2] = 1'b0;
    wr(A_PEND, 32'h04);
    rd(A_PEND, 32'h00);
    chk_irq("irq_src2_masked", 1'b0);

    // Edge coinciding with W1C: set wins
    wr(A_EN, 32'h20);
    pulse_src(8'h20);
    chk_irq("irq_src5_k", 1'b0);
    chk_irq("irq_src5_k1", 1'b1);
    rd(A_PEND, 32'h20);
    bus(1'b1, A_PEND, 32'h20, 8'h20);
    chk_irq("irq_src5_set_wins", 1'b1);
    rd(A_PEND, 32'h20);
    chk_irq("irq_src5_still", 1'b1);
    wr(A_PEND, 32'h20);
    rd(A_PEND, 32'h00);
    chk_irq("irq_src5_cleared", 1'b0);

    // Priority vector and unmapped address
    wr(A_EN, 32'hFFFF_FFFF);
    rd(A_EN, 32'h0000_00FF);
    pulse_src(8'h42);
    rd(A_STAT, 32'h42);
    rd(A_VEC,  32'h8000_0001);
    wr(A_PEND, 32'h02);
    rd(A_VEC,  32'h8000_0006);
    wr(A_PEND, 32'h40);
    rd(A_VEC,  32'h0);
    chk_irq("irq_all_cleared", 1'b0);
    wr(8'h40, 32'hFFFF_FFFF);
    rd(8'h40,  32'h0);
    rd(A_EN,   32'h0000_00FF);
    rd(A_PEND, 32'h0);
    rd(A_STAT, 32'h0);

    repeat (2) @(posedge clk);
    check("ack_count", 32'(n_acks), 32'(n_tx));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
